// File: rtl/pipeline_pkg.sv
// Shared pipeline types: NOP encoding, fetch FSM states and the IF/ID bundle.
package pipeline_pkg;

  localparam logic [31:0] NOP = 32'h0800_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus8;
    logic        valid;
  } ifid_t;

  // A bubble carries the NOP encoding so decode never sees a stale opcode.
  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.instr    = NOP;
    b.pc_plus8 = 32'h0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus: fetch drives the address, memory answers combinationally.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/ifid_register.sv
// Generic pipeline register for the IF/ID bundle with flush-over-stall priority.
module ifid_register
  import pipeline_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  flush,
  input  ifid_t din,
  output ifid_t dout
);

  ifid_t ifid_q;
  ifid_t ifid_d;

  // Flush wins over stall; a stalled register keeps every field.
  always_comb begin
    ifid_d = ifid_q;
    if (flush) begin
      ifid_d = ifid_bubble();
    end else if (!stall) begin
      ifid_d = din;
    end
  end

  // Bundle storage, cleared to a bubble on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_q <= ifid_bubble();
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign dout = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, RUN/HALT FSM, IF/ID capture and fetch counter.
//
// state | meaning
// RUN   | fetching sequentially, IF/ID loads the word at pc_f
// HALT  | PC frozen, IF/ID loads bubbles; only a branch without halt_req resumes
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_ADDR = 32'h0000_0050,
  parameter int          COUNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_f,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               halt_req,
  fetch_stage_if.master      imem,
  output logic [31:0]        pc_f,
  output logic [31:0]        instr_d,
  output logic [31:0]        pc_plus8_d,
  output logic               valid_d,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic  at_end;
  logic  run_fetch;
  logic  ifid_flush;
  logic  load_valid;
  ifid_t ifid_in;
  ifid_t ifid_out;

  // Fetch qualifiers shared by the PC, IF/ID and counter logic.
  always_comb begin
    at_end     = (pc_q >= HALT_ADDR);
    run_fetch  = (state_q == RUN) && !at_end;
    ifid_flush = branch_taken || flush_d;
    load_valid = !ifid_flush && !stall_d && run_fetch;
    ifid_in    = ifid_bubble();
    if (run_fetch) begin
      ifid_in.instr    = imem.imem_rdata;
      ifid_in.pc_plus8 = pc_q + 32'd8;
      ifid_in.valid    = 1'b1;
    end
  end

  // Next state and next PC; a branch always loads its word-aligned target.
  // At the end address the PC holds so the halted PC reads HALT_ADDR.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      RUN: begin
        if (halt_req || (at_end && !branch_taken)) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (branch_taken && !halt_req) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (branch_taken) begin
      pc_d = branch_target & ~32'h3;
    end else if ((state_q == HALT) || stall_f || at_end) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Saturating count of valid instructions handed to decode.
  always_comb begin
    count_d = count_q;
    if (load_valid && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // State, PC and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  ifid_register u_ifid (
    .clk   (clk),
    .reset (reset),
    .stall (stall_d),
    .flush (ifid_flush),
    .din   (ifid_in),
    .dout  (ifid_out)
  );

  assign imem.imem_addr = pc_q;
  assign pc_f           = pc_q;
  assign instr_d        = ifid_out.instr;
  assign pc_plus8_d     = ifid_out.pc_plus8;
  assign valid_d        = ifid_out.valid;
  assign halted         = (state_q == HALT);
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; a narrow-counter instance covers saturation.
module tb_fetch_stage;

  localparam logic [31:0] NOP_W = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f, stall_d, flush_d, branch_taken, halt_req;
  logic [31:0] branch_target;

  logic [31:0] pc_f, instr_d, pc_plus8_d;
  logic        valid_d, halted;
  logic [31:0] fetch_count;

  logic [31:0] pc_f_s, instr_d_s, pc_plus8_d_s;
  logic        valid_d_s, halted_s;
  logic [2:0]  fetch_count_s;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_stage_if mem_if ();
  fetch_stage_if mem_if_s ();

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr == 32'h0) ? 32'hEF20_000C : (32'hE000_0000 | addr);
  endfunction

  assign mem_if.imem_rdata   = mem_word(mem_if.imem_addr);
  assign mem_if_s.imem_rdata = mem_word(mem_if_s.imem_addr);

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
    .imem(mem_if), .pc_f(pc_f), .instr_d(instr_d), .pc_plus8_d(pc_plus8_d),
    .valid_d(valid_d), .halted(halted), .fetch_count(fetch_count)
  );

  fetch_stage #(.COUNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
    .imem(mem_if_s), .pc_f(pc_f_s), .instr_d(instr_d_s), .pc_plus8_d(pc_plus8_d_s),
    .valid_d(valid_d_s), .halted(halted_s), .fetch_count(fetch_count_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0;
    branch_taken = 0; branch_target = 0; halt_req = 0;
    step(); step();
    n_cmp++; if (pc_f !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_f, 32'h0); end
    n_cmp++; if (instr_d !== NOP_W) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr_d, NOP_W); end
    n_cmp++; if (pc_plus8_d !== 32'h0 || valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_ifid: got pc8=%h v=%b want 0/0", pc_plus8_d, valid_d); end
    n_cmp++; if (fetch_count !== 32'h0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_halt: got cnt=%0d h=%b want 0/0", fetch_count, halted); end
    #3 reset = 1'b0;
  endtask

  task automatic test_free_run();
    step();
    n_cmp++; if (instr_d !== 32'hEF20_000C) begin n_fail++; $display("FAIL run_instr0: got %h want %h", instr_d, 32'hEF20_000C); end
    n_cmp++; if (pc_plus8_d !== 32'h8 || valid_d !== 1'b1) begin n_fail++; $display("FAIL run_pc8_0: got pc8=%h v=%b want 8/1", pc_plus8_d, valid_d); end
    n_cmp++; if (pc_f !== 32'h4) begin n_fail++; $display("FAIL run_pc1: got %h want %h", pc_f, 32'h4); end
    step(); step();
    n_cmp++; if (pc_f !== 32'hC || fetch_count !== 32'd3) begin n_fail++; $display("FAIL run_pc3: got pc=%h cnt=%0d want 0c/3", pc_f, fetch_count); end
  endtask

  task automatic test_stall();
    stall_f = 1; stall_d = 1;
    step(); step(); step();
    n_cmp++; if (pc_f !== 32'hC) begin n_fail++; $display("FAIL stall_pc: got %h want %h", pc_f, 32'hC); end
    n_cmp++; if (instr_d !== 32'hE000_0008 || fetch_count !== 32'd3) begin n_fail++; $display("FAIL stall_ifid: got instr=%h cnt=%0d want e0000008/3", instr_d, fetch_count); end
    stall_f = 0; stall_d = 0;
    step();
    n_cmp++; if (pc_f !== 32'h10 || instr_d !== 32'hE000_000C || fetch_count !== 32'd4) begin n_fail++; $display("FAIL stall_release: got pc=%h instr=%h cnt=%0d want 10/e000000c/4", pc_f, instr_d, fetch_count); end
  endtask

  task automatic test_branch_over_stall();
    repeat (5) step();
    n_cmp++; if (pc_f !== 32'h24) begin n_fail++; $display("FAIL br_setup_pc: got %h want %h", pc_f, 32'h24); end
    branch_taken = 1; branch_target = 32'h0E; stall_f = 1; stall_d = 1;
    step();
    branch_taken = 0; stall_f = 0; stall_d = 0;
    n_cmp++; if (pc_f !== 32'hC) begin n_fail++; $display("FAIL br_pc: got %h want %h", pc_f, 32'hC); end
    n_cmp++; if (valid_d !== 1'b0 || instr_d !== NOP_W || fetch_count !== 32'd9) begin n_fail++; $display("FAIL br_bubble: got v=%b instr=%h cnt=%0d want 0/08000000/9", valid_d, instr_d, fetch_count); end
    step();
    n_cmp++; if (valid_d !== 1'b1 || instr_d !== 32'hE000_000C || pc_plus8_d !== 32'h14) begin n_fail++; $display("FAIL br_target_word: got v=%b instr=%h pc8=%h want 1/e000000c/14", valid_d, instr_d, pc_plus8_d); end
  endtask

  task automatic test_halt_end();
    int n;
    n = 0;
    while (pc_f !== 32'h50 && n < 40) begin step(); n++; end
    n_cmp++; if (pc_f !== 32'h50 || fetch_count !== 32'd26) begin n_fail++; $display("FAIL end_reach: got pc=%h cnt=%0d want 50/26", pc_f, fetch_count); end
    step();
    n_cmp++; if (halted !== 1'b1 || pc_f !== 32'h50 || valid_d !== 1'b0) begin n_fail++; $display("FAIL end_halt: got h=%b pc=%h v=%b want 1/50/0", halted, pc_f, valid_d); end
    step(); step();
    n_cmp++; if (halted !== 1'b1 || pc_f !== 32'h50 || valid_d !== 1'b0 || fetch_count !== 32'd26) begin n_fail++; $display("FAIL end_hold: got h=%b pc=%h v=%b cnt=%0d want 1/50/0/26", halted, pc_f, valid_d, fetch_count); end
    branch_taken = 1; branch_target = 32'h14;
    step();
    branch_taken = 0;
    n_cmp++; if (halted !== 1'b0 || pc_f !== 32'h14 || valid_d !== 1'b0) begin n_fail++; $display("FAIL end_resume: got h=%b pc=%h v=%b want 0/14/0", halted, pc_f, valid_d); end
    step();
    n_cmp++; if (instr_d !== 32'hE000_0014 || pc_plus8_d !== 32'h1C || fetch_count !== 32'd27) begin n_fail++; $display("FAIL end_refetch: got instr=%h pc8=%h cnt=%0d want e0000014/1c/27", instr_d, pc_plus8_d, fetch_count); end
  endtask

  task automatic test_async_reset();
    branch_taken = 1; branch_target = 32'h08;
    step();
    branch_taken = 0; halt_req = 1;
    step();
    halt_req = 0;
    n_cmp++; if (halted !== 1'b1 || pc_f !== 32'hC || fetch_count !== 32'd28) begin n_fail++; $display("FAIL hreq: got h=%b pc=%h cnt=%0d want 1/0c/28", halted, pc_f, fetch_count); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (pc_f !== 32'h0 || halted !== 1'b0 || fetch_count !== 32'h0) begin n_fail++; $display("FAIL areset_state: got pc=%h h=%b cnt=%0d want 0/0/0", pc_f, halted, fetch_count); end
    n_cmp++; if (instr_d !== NOP_W || valid_d !== 1'b0 || pc_plus8_d !== 32'h0) begin n_fail++; $display("FAIL areset_ifid: got instr=%h v=%b pc8=%h want 08000000/0/0", instr_d, valid_d, pc_plus8_d); end
    step();
    #3 reset = 1'b0;
  endtask

  task automatic test_branch_with_halt();
    branch_taken = 1; halt_req = 1; branch_target = 32'h33;
    step();
    branch_taken = 0; halt_req = 0;
    n_cmp++; if (pc_f !== 32'h30 || halted !== 1'b1 || valid_d !== 1'b0) begin n_fail++; $display("FAIL brhalt: got pc=%h h=%b v=%b want 30/1/0", pc_f, halted, valid_d); end
    step();
    n_cmp++; if (pc_f !== 32'h30 || halted !== 1'b1 || fetch_count !== 32'h0) begin n_fail++; $display("FAIL brhalt_hold: got pc=%h h=%b cnt=%0d want 30/1/0", pc_f, halted, fetch_count); end
  endtask

  task automatic test_saturate();
    reset = 1'b1;
    #2;
    n_cmp++; if (fetch_count_s !== 3'd0) begin n_fail++; $display("FAIL sat_reset: got %0d want 0", fetch_count_s); end
    step();
    #3 reset = 1'b0;
    repeat (6) step();
    n_cmp++; if (fetch_count_s !== 3'd6) begin n_fail++; $display("FAIL sat_count6: got %0d want 6", fetch_count_s); end
    step();
    n_cmp++; if (fetch_count_s !== 3'd7) begin n_fail++; $display("FAIL sat_count7: got %0d want 7", fetch_count_s); end
    repeat (3) step();
    n_cmp++; if (fetch_count_s !== 3'd7 || fetch_count !== 32'd10) begin n_fail++; $display("FAIL sat_hold: got small=%0d main=%0d want 7/10", fetch_count_s, fetch_count); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_branch_over_stall();
    test_halt_end();
    test_async_reset();
    test_branch_with_halt();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage ARM-subset pipeline.
- Owns the program counter and drives the address of the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register consumed by decode.
- Applies stall, flush and branch redirect from the hazard unit and execute, and halts fetch at end of program.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_ADDR, 32'h0000_0050, first byte address past the program; reaching it halts fetch.
- COUNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- stall_f  input  1  hold PC
- stall_d  input  1  hold IF/ID register
- flush_d  input  1  replace IF/ID contents with a bubble
- branch_taken  input  1  redirect request from execute
- branch_target  input  32  redirect byte address
- halt_req  input  1  external halt request
- imem_addr  output  32  address to instruction memory (equals pc_f)
- imem_rdata  input  32  instruction word, combinational from imem_addr
- pc_f  output  32  current fetch PC
- instr_d  output  32  IF/ID instruction
- pc_plus8_d  output  32  IF/ID PC+8 (ARM read value of R15)
- valid_d  output  1  IF/ID holds a real instruction
- halted  output  1  FSM in HALT
- fetch_count  output  COUNT_W  valid instructions delivered to decode

Behaviour:
- Reset is asynchronous, active-high, and fixed. On reset:
  - pc_f = RESET_PC, state RUN.
  - instr_d = NOP (32'h0800_0000), pc_plus8_d = 0, valid_d = 0.
  - fetch_count = 0, halted = 0.
- Reset asserted mid-operation discards everything immediately. No partial state survives.
- imem_addr = pc_f, combinational. The word at pc_f enters IF/ID on the next rising edge, so fetch-to-decode latency is 1 cycle.
- Branch targets are aligned: bits [1:0] of branch_target are forced to 0 on load.
- FSM states:
  - RUN:
    - Fetches sequentially.
    - Goes to HALT when halt_req=1, or when pc_f >= HALT_ADDR with branch_taken=0.
  - HALT:
    - PC frozen.
    - IF/ID loads bubbles (NOP, valid 0) unless stall_d.
    - Leaves to RUN only on branch_taken=1 with halt_req=0.
- PC update priority, highest first:
  - branch_taken: pc <= target. Overrides stall_f and HALT. If halt_req is also 1, the target is loaded but the state becomes or stays HALT.
  - HALT or stall_f: pc holds.
  - Otherwise: pc <= pc+4. Wraps modulo 2^32 with no error.
- IF/ID update priority, highest first:
  - branch_taken or flush_d: load bubble (NOP, pc_plus8 0, valid 0). Overrides stall_d.
  - stall_d: hold all IF/ID fields.
  - HALT, or RUN with pc_f >= HALT_ADDR: load bubble.
  - Otherwise: instr_d <= imem_rdata, pc_plus8_d <= pc_f+8, valid_d <= 1.
- stall_f=1 with stall_d=0 is legal. The same word is re-captured each cycle; the hazard unit is responsible for the consequences.
- fetch_count increments by 1 on every edge where valid_d is loaded with 1. It saturates at all-ones and is never cleared except by reset.
- halted = (state == HALT), registered.

Decomposition:
- Shared package pipeline_pkg: NOP constant 32'h0800_0000, state enum {RUN, HALT}, and the IF/ID bundle struct (instr, pc_plus8, valid), shared with decode.
- One natural sub-module: ifid_register. It holds the IF/ID bundle with stall/flush controls and is reused by later pipeline registers.
- The PC logic and FSM stay in fetch_stage.

Test Plan:
- Reset then free-run, imem returns 32'hEF2000_0C at address 0 -> cycle 1: instr_d=32'hEF20000C, pc_plus8_d=8, valid_d=1; pc_f steps 0,4,8,...
- stall_f=stall_d=1 for 3 cycles at pc_f=0x0C -> pc_f, instr_d and fetch_count unchanged; on release pc_f=0x10 next edge.
- branch_taken=1, target 0x0E, asserted together with stall_f=stall_d=1 at pc_f=0x24 -> next edge pc_f=0x0C, valid_d=0, instr_d=NOP; following edge valid_d=1 with the word at 0x0C.
- Free-run to pc_f=0x50 -> halted=1 next edge, pc_f stays 0x50, valid_d=0 thereafter; then branch_taken with target 0x14 -> halted=0, pc_f=0x14.
- halt_req pulsed at pc_f=0x08, then reset asserted asynchronously between edges -> outputs return to reset values immediately; fetch_count=0.
- Force fetch_count near all-ones and run -> fetch_count holds at all-ones without wrapping.
